// File: rtl/scrub_bram_pkg.sv
// Shared types and constants for the scrubbable byte-lane block RAM.
package scrub_bram_pkg;

    localparam int unsigned LANE_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SCRUB = 1'b1
    } state_t;

endpackage

// File: rtl/scrub_bram_lane.sv
// One byte lane of the RAM: DEPTH x 8 storage, synchronous write, asynchronous read.
module scrub_bram_lane
    import scrub_bram_pkg::*;
#(
    parameter int unsigned DEPTH = 8192,
    parameter int unsigned LW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LW-1:0]     addr,
    input  logic [LANE_W-1:0] din,
    output logic [LANE_W-1:0] dout
);

    logic [LANE_W-1:0] mem [DEPTH];

    // Storage is deliberately never reset; only a scrub clears it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/scrub_bram.sv
// Byte-writable single-port RAM with registered read, idle-cycle output flush,
// and a full-array scrub engine that overwrites every word with scrub_data.
module scrub_bram
    import scrub_bram_pkg::*;
#(
    parameter int unsigned DEPTH  = 8192,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 15
) (
    input  logic                         g_clk,
    input  logic                         g_resetn,
    input  logic                         ena,
    input  logic [DATA_W/LANE_W-1:0]     wea,
    input  logic [ADDR_W-1:0]            addra,
    input  logic [DATA_W-1:0]            dina,
    output logic [DATA_W-1:0]            douta,
    input  logic                         flush_rand,
    input  logic [DATA_W-1:0]            flush_data,
    input  logic                         scrub_req,
    input  logic [DATA_W-1:0]            scrub_data,
    output logic                         busy,
    output logic                         scrub_done
);

    localparam int unsigned NB = DATA_W / LANE_W;
    localparam int unsigned LB = $clog2(NB);
    localparam int unsigned LW = $clog2(DEPTH);

    state_t            state;
    logic [LW-1:0]     cnt;
    logic [LW-1:0]     word_idx;
    logic [LW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] rd_word;
    logic              scrubbing;
    logic              unused_addr_bits;

    // Address bits above the word index are don't-care; words alias modulo DEPTH.
    assign word_idx         = addra[LB +: LW];
    assign unused_addr_bits = ^addra;

    assign scrubbing = (state == ST_SCRUB);
    assign mem_addr  = scrubbing ? cnt : word_idx;
    assign mem_din   = scrubbing ? scrub_data : dina;

    for (genvar k = 0; k < NB; k++) begin : g_lane
        logic lane_we;

        assign lane_we = (!scrubbing && ena && wea[k]) || scrubbing;

        scrub_bram_lane #(
            .DEPTH (DEPTH),
            .LW    (LW)
        ) u_lane (
            .clk  (g_clk),
            .we   (lane_we),
            .addr (mem_addr),
            .din  (mem_din[k*LANE_W +: LANE_W]),
            .dout (rd_word[k*LANE_W +: LANE_W])
        );
    end

    // Control FSM and registered read/flush/scrub output path.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            douta      <= '0;
            busy       <= 1'b0;
            scrub_done <= 1'b0;
        end else begin
            scrub_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ena && (wea == '0)) begin
                        douta <= rd_word;
                    end else if (!ena && flush_rand) begin
                        douta <= flush_data;
                    end
                    if (scrub_req) begin
                        state <= ST_SCRUB;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_SCRUB: begin
                    douta <= scrub_data;
                    if (cnt == LW'(DEPTH - 1)) begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        busy       <= 1'b0;
                        scrub_done <= 1'b1;
                    end else begin
                        cnt <= cnt + LW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scrub_bram.sv
// Directed self-checking bench for scrub_bram with a 16-word, 32-bit configuration.
module tb_scrub_bram;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 15;

    logic              g_clk = 1'b0;
    logic              g_resetn;
    logic              ena;
    logic [3:0]        wea;
    logic [ADDR_W-1:0] addra;
    logic [31:0]       dina;
    logic [31:0]       douta;
    logic              flush_rand;
    logic [31:0]       flush_data;
    logic              scrub_req;
    logic [31:0]       scrub_data;
    logic              busy;
    logic              scrub_done;

    int n_checks = 0;
    int n_fail   = 0;

    scrub_bram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .ena        (ena),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .douta      (douta),
        .flush_rand (flush_rand),
        .flush_data (flush_data),
        .scrub_req  (scrub_req),
        .scrub_data (scrub_data),
        .busy       (busy),
        .scrub_done (scrub_done)
    );

    always #5 g_clk = ~g_clk;

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] we);
        ena   = 1'b1;
        wea   = we;
        addra = a;
        dina  = d;
        @(posedge g_clk); #1;
        ena = 1'b0;
        wea = 4'h0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
        ena   = 1'b1;
        wea   = 4'h0;
        addra = a;
        @(posedge g_clk); #1;
        ena = 1'b0;
        d   = douta;
    endtask

    task automatic test_reset;
        g_resetn = 1'b0; ena = 1'b0; wea = 4'h0; addra = '0; dina = '0;
        flush_rand = 1'b0; flush_data = '0; scrub_req = 1'b0; scrub_data = '0;
        #1;
        n_checks++;
        if (douta !== 32'h0) begin n_fail++; $display("FAIL reset_douta: got %h expected %h", douta, 32'h0); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (scrub_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", scrub_done); end
        repeat (2) @(posedge g_clk);
        #1 g_resetn = 1'b1;
    endtask

    task automatic test_write_read;
        logic [31:0] d;
        do_write(15'h0008, 32'hDEADBEEF, 4'hF);
        do_read(15'h0008, d);
        n_checks++;
        if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_read: got %h expected %h", d, 32'hDEADBEEF); end
        do_write(15'h0010, 32'h01020304, 4'hF);
        n_checks++;
        if (douta !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_holds_douta: got %h expected %h", douta, 32'hDEADBEEF); end
    endtask

    task automatic test_byte_lane;
        logic [31:0] d;
        do_write(15'h0004, 32'h11223344, 4'hF);
        do_write(15'h0004, 32'h000000AA, 4'h1);
        do_read(15'h0004, d);
        n_checks++;
        if (d !== 32'h112233AA) begin n_fail++; $display("FAIL lane0_write: got %h expected %h", d, 32'h112233AA); end
        do_write(15'h0004, 32'h00CC0000, 4'h4);
        do_read(15'h0004, d);
        n_checks++;
        if (d !== 32'h11CC33AA) begin n_fail++; $display("FAIL lane2_write: got %h expected %h", d, 32'h11CC33AA); end
    endtask

    task automatic test_alias;
        logic [31:0] d;
        do_read(15'h0048, d);
        n_checks++;
        if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alias_0x48: got %h expected %h", d, 32'hDEADBEEF); end
        do_read(15'h7FC8, d);
        n_checks++;
        if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alias_0x7fc8: got %h expected %h", d, 32'hDEADBEEF); end
    endtask

    task automatic test_back_to_back;
        ena = 1'b1; wea = 4'h0; addra = 15'h0008;
        @(posedge g_clk); #1;
        n_checks++;
        if (douta !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", douta, 32'hDEADBEEF); end
        addra = 15'h0004;
        @(posedge g_clk); #1;
        n_checks++;
        if (douta !== 32'h11CC33AA) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", douta, 32'h11CC33AA); end
        addra = 15'h0010;
        @(posedge g_clk); #1;
        ena = 1'b0;
        n_checks++;
        if (douta !== 32'h01020304) begin n_fail++; $display("FAIL b2b_third: got %h expected %h", douta, 32'h01020304); end
    endtask

    task automatic test_flush;
        ena = 1'b0; flush_rand = 1'b1; flush_data = 32'h5A5A5A5A;
        @(posedge g_clk); #1;
        n_checks++;
        if (douta !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL flush_load: got %h expected %h", douta, 32'h5A5A5A5A); end
        flush_rand = 1'b0; flush_data = 32'h0BADF00D;
        @(posedge g_clk); #1;
        n_checks++;
        if (douta !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL flush_hold: got %h expected %h", douta, 32'h5A5A5A5A); end
        // A read cycle takes priority over flush.
        flush_rand = 1'b1; ena = 1'b1; wea = 4'h0; addra = 15'h0008;
        @(posedge g_clk); #1;
        n_checks++;
        if (douta !== 32'hDEADBEEF) begin n_fail++; $display("FAIL flush_vs_read: got %h expected %h", douta, 32'hDEADBEEF); end
        wea = 4'hF; addra = 15'h001C; dina = 32'h77777777;
        @(posedge g_clk); #1;
        ena = 1'b0; wea = 4'h0; flush_rand = 1'b0;
        n_checks++;
        if (douta !== 32'hDEADBEEF) begin n_fail++; $display("FAIL flush_vs_write: got %h expected %h", douta, 32'hDEADBEEF); end
    endtask

    task automatic test_scrub;
        int busy_cnt;
        int done_cnt;
        bit finished;
        logic [31:0] d;
        do_write(15'h0000, 32'hCAFEF00D, 4'hF);
        ena = 1'b1; wea = 4'h0; addra = 15'h0000; scrub_req = 1'b1; scrub_data = 32'h0;
        @(posedge g_clk); #1;
        n_checks++;
        if (douta !== 32'hCAFEF00D) begin n_fail++; $display("FAIL scrub_coincident_read: got %h expected %h", douta, 32'hCAFEF00D); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL scrub_busy_rise: got %b expected 1", busy); end
        busy_cnt = 1; done_cnt = 0; finished = 1'b0;
        wea = 4'hF; dina = 32'hFFFFFFFF; flush_rand = 1'b1; flush_data = 32'h12345678;
        for (int i = 0; i < 40; i++) begin
            addra = ADDR_W'((i * 4) % 64);
            @(posedge g_clk); #1;
            if (scrub_done === 1'b1) done_cnt++;
            n_checks++;
            if (douta !== 32'h0) begin n_fail++; $display("FAIL scrub_douta cycle %0d: got %h expected %h", i, douta, 32'h0); end
            if (busy === 1'b1) begin
                busy_cnt++;
            end else begin
                finished = 1'b1;
                break;
            end
        end
        ena = 1'b0; wea = 4'h0; flush_rand = 1'b0; scrub_req = 1'b0;
        n_checks++;
        if (!finished) begin n_fail++; $display("FAIL scrub_timeout: busy still %b, expected 0 within 40 cycles", busy); end
        @(posedge g_clk); #1;
        n_checks++;
        if (busy_cnt != 16) begin n_fail++; $display("FAIL scrub_busy_len: got %0d expected 16", busy_cnt); end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL scrub_done_pulses: got %0d expected 1", done_cnt); end
        n_checks++;
        if (scrub_done !== 1'b0) begin n_fail++; $display("FAIL scrub_done_drop: got %b expected 0", scrub_done); end
        for (int w = 0; w < 16; w++) begin
            do_read(ADDR_W'(w * 4), d);
            n_checks++;
            if (d !== 32'h0) begin n_fail++; $display("FAIL scrub_word %0d: got %h expected %h", w, d, 32'h0); end
        end
    endtask

    task automatic test_reset_during_scrub;
        logic [31:0] d;
        logic [31:0] exp;
        for (int w = 0; w < 16; w++) begin
            do_write(ADDR_W'(w * 4), 32'hA5000000 | 32'(w), 4'hF);
        end
        scrub_data = 32'h0F0F0F0F; scrub_req = 1'b1;
        @(posedge g_clk); #1;
        scrub_req = 1'b0;
        repeat (5) @(posedge g_clk);
        #1;
        n_checks++;
        if (douta !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL abort_pre_douta: got %h expected %h", douta, 32'h0F0F0F0F); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b expected 1", busy); end
        g_resetn = 1'b0;
        #1;
        n_checks++;
        if (douta !== 32'h0) begin n_fail++; $display("FAIL abort_douta: got %h expected %h", douta, 32'h0); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++;
        if (scrub_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", scrub_done); end
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        for (int w = 0; w < 16; w++) begin
            exp = (w < 5) ? 32'h0F0F0F0F : (32'hA5000000 | 32'(w));
            do_read(ADDR_W'(w * 4), d);
            n_checks++;
            if (d !== exp) begin n_fail++; $display("FAIL abort_word %0d: got %h expected %h", w, d, exp); end
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_no_restart: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lane();
        test_alias();
        test_back_to_back();
        test_flush();
        test_scrub();
        test_reset_during_scrub();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scrub_bram.md
SCRUB_BRAM -- requirements
Module: scrub_bram

Interface
- REQ-001: Parameter DEPTH, default 8192: memory depth in words; SHALL be a power of two, >= 2.
- REQ-002: Parameter DATA_W, default 32: word width in bits; SHALL be a multiple of 8; NB = DATA_W/8 byte lanes.
- REQ-003: Parameter ADDR_W, default 15: byte-address width; SHALL be >= log2(DEPTH) + log2(NB).
- REQ-004: g_clk  in  1  sole clock; all state updates on rising edge.
- REQ-005: g_resetn  in  1  asynchronous, active-low reset.
- REQ-006: ena  in  1  access enable.
- REQ-007: wea  in  NB  per-byte-lane write enables; any bit set makes the access a write.
- REQ-008: addra  in  ADDR_W  byte address; word index = addra[log2(NB)+LW-1 : log2(NB)], where LW = log2(DEPTH).
- REQ-009: dina  in  DATA_W  write data.
- REQ-010: douta  out  DATA_W  registered read data.
- REQ-011: flush_rand  in  1  replaces douta with flush_data on idle cycles.
- REQ-012: flush_data  in  DATA_W  random flush value.
- REQ-013: scrub_req  in  1  single-cycle request to overwrite the whole array.
- REQ-014: scrub_data  in  DATA_W  value written during scrub; sampled every scrub cycle.
- REQ-015: busy  out  1  registered; high while a scrub is in progress.
- REQ-016: scrub_done  out  1  registered single-cycle completion pulse.

Function
- REQ-017: FSM states: IDLE and SCRUB; encoding comes from the shared package.
- REQ-018: IDLE, ena=1, wea=0: douta SHALL equal the addressed word on the next edge (1-cycle latency).
- REQ-019: IDLE, ena=1, wea!=0: each lane k with wea[k]=1 SHALL write dina[8k+7:8k]; douta SHALL hold.
- REQ-020: IDLE, ena=0, flush_rand=1: douta SHALL load flush_data; ena=0, flush_rand=0: douta SHALL hold.
- REQ-021: addra bits above the word index SHALL be ignored; indices alias modulo DEPTH.
- REQ-022: IDLE, scrub_req=1: the FSM SHALL enter SCRUB next cycle with word counter 0 and busy=1; a coincident ena access SHALL complete normally that cycle.
- REQ-023: SCRUB cycle n (n = 0..DEPTH-1): word n SHALL be written with scrub_data on all lanes, and douta SHALL load scrub_data.
- REQ-024: SCRUB SHALL ignore ena, wea, flush_rand and scrub_req; no user write occurs, and no array content reaches douta.
- REQ-025: After the write of word DEPTH-1, the FSM SHALL return to IDLE; busy falls and scrub_done=1 for exactly one cycle on that same edge.
- REQ-026: A scrub SHALL last exactly DEPTH cycles; the counter SHALL be LW bits and SHALL not wrap past DEPTH-1 within a scrub.

Reset
- REQ-027: While g_resetn=0: douta=0, busy=0, scrub_done=0, state=IDLE, counter=0; asserted and cleared asynchronously.
- REQ-028: Array contents SHALL NOT be reset; a reset during SCRUB aborts it and leaves the array partially scrubbed.
- REQ-029: The first access after reset release SHALL follow REQ-018..REQ-020.

Structure
- REQ-030: Shared package scrub_bram_pkg SHALL hold the FSM state enum and the byte-lane width constant (8).
- REQ-031: Sub-module scrub_bram_lane SHALL implement one DEPTH x 8 array with a synchronous write port and an asynchronous read; it SHALL be instantiated NB times.
- REQ-032: Lane write enable = (IDLE & ena & wea[k]) | SCRUB; lane address and data SHALL be muxed between the user port and the scrub counter.

Verification (DEPTH=16, DATA_W=32)
- REQ-033: Write 0xDEADBEEF at 0x8 with wea=0xF, then read 0x8 -> douta=0xDEADBEEF one cycle after the read.
- REQ-034: Write 0x000000AA at 0x4 with wea=0x1 over a previous 0x11223344 -> read returns 0x112233AA.
- REQ-035: ena=0, flush_rand=1, flush_data=0x5A5A5A5A -> douta=0x5A5A5A5A next cycle; flush_rand=0 -> douta holds.
- REQ-036: scrub_req with scrub_data=0 -> busy high 16 cycles, scrub_done pulses once, all 16 words read 0, and user writes issued during busy do not land.
- REQ-037: Deassert g_resetn at scrub cycle 5 -> douta, busy and scrub_done go 0 immediately, words 0-4 are scrubbed, and word 5 onward is unchanged.
- REQ-038: Read 0x0 in the same cycle as scrub_req -> douta returns the pre-scrub word 0, and busy rises next cycle.
